encoder32_5: RTL and testbench

ENCODER32_5 -- requirements
Module: encoder32_5

---
 rtl/encoder32_5.sv | 116 +++++++++++
 tb/tb_encoder32_5.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/encoder32_5.sv
`default_nettype none
// ============================================================================
//  Module   : encoder32_5
//  Brief    : Serialises a 32-bit register mask into a stream of 5-bit
//             register numbers with a valid/ready handshake.
//  Revision : 1.0
// ============================================================================
module encoder32_5 #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] mask,
    input  logic        ready,
    output logic        valid,
    output logic [4:0]  reg_no,
    output logic [5:0]  count,
    output logic        busy,
    output logic        done
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    localparam logic [31:0] c_ONE = 32'd1;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pending;
    logic [31:0] w_pending_nxt;
    logic        r_done;
    logic        w_done_nxt;
    logic [4:0]  w_sel;
    logic [5:0]  w_pop;
    logic [31:0] w_cleared;
    logic        w_emit;

    // Later loop iterations overwrite earlier ones, so the scan direction
    // decides whether the lowest or highest set bit wins.
    always_comb begin
        w_sel = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < 32; i++) begin
                if (r_pending[i]) w_sel = 5'(i);
            end
        end else begin
            for (int i = 31; i >= 0; i--) begin
                if (r_pending[i]) w_sel = 5'(i);
            end
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < 32; i++) begin
            w_pop = w_pop + {5'd0, r_pending[i]};
        end
    end

    assign w_cleared = r_pending & ~(c_ONE << w_sel);
    assign w_emit    = (r_state == S_EMIT);

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_done_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (load) begin
                    if (mask != 32'd0) begin
                        w_pending_nxt = mask;
                        w_state_nxt   = S_EMIT;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            S_EMIT: begin
                if (ready) begin
                    w_pending_nxt = w_cleared;
                    if (w_cleared == 32'd0) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_pending_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign valid  = w_emit;
    assign busy   = w_emit;
    assign done   = r_done;
    assign reg_no = w_emit ? w_sel : 5'd0;
    assign count  = w_emit ? w_pop : 6'd0;

endmodule
`default_nettype wire

// File: tb/tb_encoder32_5.sv
`default_nettype none
// ============================================================================
//  Module   : tb_encoder32_5
//  Brief    : Scoreboard bench for encoder32_5, LSB-first and MSB-first copies.
//  Revision : 1.0
// ============================================================================
module tb_encoder32_5;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [31:0] mask;
    logic        ready;
    logic        valid0, busy0, done0, valid1, busy1, done1;
    logic [4:0]  reg_no0, reg_no1;
    logic [5:0]  count0, count1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0] q_lsb[$];
    logic [10:0] q_msb[$];

    always #5 clk = ~clk;

    encoder32_5 #(.MSB_FIRST(1'b0)) u_dut_lsb (
        .clk(clk), .reset(reset), .load(load), .mask(mask), .ready(ready),
        .valid(valid0), .reg_no(reg_no0), .count(count0), .busy(busy0), .done(done0)
    );

    encoder32_5 #(.MSB_FIRST(1'b1)) u_dut_msb (
        .clk(clk), .reset(reset), .load(load), .mask(mask), .ready(ready),
        .valid(valid1), .reg_no(reg_no1), .count(count1), .busy(busy1), .done(done1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected {count, reg_no} sequences for both scan orders.
    task automatic push_job(input logic [31:0] m);
        int n;
        n = $countones(m);
        for (int i = 0; i < 32; i++) begin
            if (m[i]) begin
                q_lsb.push_back({6'(n), 5'(i)});
                n--;
            end
        end
        n = $countones(m);
        for (int i = 31; i >= 0; i--) begin
            if (m[i]) begin
                q_msb.push_back({6'(n), 5'(i)});
                n--;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int k;
        k = 0;
        while (!done0 && k < bound) begin
            tick();
            k++;
        end
        check_eq({tag, "_done_lsb"}, 32'(done0), 32'd1);
        check_eq({tag, "_done_msb"}, 32'(done1), 32'd1);
        check_eq({tag, "_done_novalid"}, 32'(valid0), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (valid0 && ready) begin
                if (q_lsb.size() == 0) check_eq("lsb_unexpected_xfer", 32'd1, 32'd0);
                else check_eq("lsb_xfer", {21'd0, count0, reg_no0}, {21'd0, q_lsb.pop_front()});
            end
            if (valid1 && ready) begin
                if (q_msb.size() == 0) check_eq("msb_unexpected_xfer", 32'd1, 32'd0);
                else check_eq("msb_xfer", {21'd0, count1, reg_no1}, {21'd0, q_msb.pop_front()});
            end
            if (done0) check_eq("done_with_valid", 32'(valid0), 32'd0);
            if (valid0 != busy0) check_eq("busy_eq_valid", 32'(busy0), 32'(valid0));
        end
    end

    initial begin
        reset = 1'b1; load = 1'b0; mask = '0; ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check_eq("rst_state", {valid0, busy0, done0, reg_no0, count0}, 32'd0);
        check_eq("rst_state_msb", {valid1, busy1, done1, reg_no1, count1}, 32'd0);

        // Basic job with exact timing: transfers N+1..N+3, done at N+4.
        load = 1'b1; mask = 32'h8000_0011; push_job(mask);
        tick(); load = 1'b0; mask = '0;
        check_eq("t1_first_valid", 32'(valid0), 32'd1);
        tick(); tick(); tick();
        check_eq("t1_done", 32'(done0), 32'd1);
        check_eq("t1_done_valid", 32'(valid0), 32'd0);
        tick();
        check_eq("t1_done_pulse", 32'(done0), 32'd0);

        // Backpressure: ready low for two cycles holds outputs stable.
        load = 1'b1; mask = 32'h8000_0011; push_job(mask);
        tick(); load = 1'b0; ready = 1'b0;
        for (int s = 0; s < 2; s++) begin
            check_eq("t2_hold_lsb", {reg_no0, count0}, {5'd0, 6'd3});
            check_eq("t2_hold_msb", {reg_no1, count1}, {5'd31, 6'd3});
            tick();
        end
        ready = 1'b1;
        wait_done("t2", 10);
        tick();

        // Empty mask: done next cycle, never valid.
        load = 1'b1; mask = 32'd0;
        tick(); load = 1'b0;
        check_eq("t3_done", 32'(done0), 32'd1);
        check_eq("t3_novalid", 32'(valid0 | valid1), 32'd0);
        tick();
        check_eq("t3_pulse", 32'(done0), 32'd0);
        check_eq("t3_novalid2", 32'(valid0), 32'd0);

        // Full mask, loads during busy ignored, back-to-back job in done cycle.
        load = 1'b1; mask = 32'hFFFF_FFFF; push_job(mask);
        tick(); mask = 32'h1;
        tick(); tick(); load = 1'b0; mask = '0;
        wait_done("t4", 40);
        load = 1'b1; mask = 32'h6; push_job(mask);
        tick(); load = 1'b0;
        check_eq("t4_b2b_valid", 32'(valid0), 32'd1);
        wait_done("t4b", 10);
        check_eq("t4_q_empty", q_lsb.size() + q_msb.size(), 32'd0);
        tick();

        // Reset mid-job after two transfers.
        load = 1'b1; mask = 32'h0000_000F; push_job(mask);
        tick(); load = 1'b0;
        tick(); tick();
        reset = 1'b1; ready = 1'b0;
        tick();
        check_eq("t5_rst_outs", {valid0, busy0, done0, reg_no0, count0}, 32'd0);
        q_lsb.delete(); q_msb.delete();
        reset = 1'b0; ready = 1'b1; load = 1'b1; mask = 32'h4; push_job(mask);
        tick(); load = 1'b0;
        check_eq("t5_no_done", 32'(done0), 32'd0);
        check_eq("t5_regno", 32'(reg_no0), 32'd2);
        wait_done("t5", 5);
        check_eq("end_q_empty", q_lsb.size() + q_msb.size(), 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
